// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg
// Shared definitions for the SPI register-bus command controller:
//   - spi_reg_state_t : controller state encoding
//   - CMD_WR_BIT      : command byte bit selecting write (1) or read (0)
//   - DEFAULT_SYNC_BYTE : byte returned while the command byte is shifted in
package spi_reg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        CMD,
        WR,
        RD_REQ,
        RD_CAP,
        RD_LOAD,
        RD_WAIT,
        DONE
    } spi_reg_state_t;

    localparam int         CMD_WR_BIT        = 7;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h5A;

endpackage

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
// Decodes bytes received by spi_slave into read/write transactions on the
// configuration/status register bus and returns read data to the slave's
// transmit path. Sole master of the register bus.
//
// Optional build macro: SPI_REG_CTRL_BURST_EN
//   defined     : burst access, address auto-increments until the frame ends
//   not defined : exactly one register accessed per frame
//
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   frame_active       : slave selected (synchronized, active high)
//   rx_valid, rx_byte  : received byte strobe and data
//   tx_byte, tx_load   : next byte to shift out and its load strobe
//   reg_addr, reg_we, reg_wdata, reg_re, reg_rdata : register bus
//   busy               : controller not in IDLE
//   err                : sticky error (invalid command or read overrun)
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_we,
    output logic [7:0]        reg_wdata,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              err
);

    spi_reg_state_t    r_state, w_state_next;
    logic              r_fa_prev;
    logic [7:0]        r_tx_byte, w_tx_byte_next;
    logic              r_tx_load, w_tx_load_next;
    logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_next;
    logic              r_reg_we, w_reg_we_next;
    logic [7:0]        r_reg_wdata, w_reg_wdata_next;
    logic              r_reg_re, w_reg_re_next;
    logic              r_busy, w_busy_next;
    logic              r_err, w_err_next;
    logic              w_cmd_bad;

    // Any set bit between the address field and the write flag rejects the command.
    assign w_cmd_bad = |(rx_byte[6:0] >> ADDR_W);

    always_comb begin
        w_state_next     = r_state;
        w_tx_byte_next   = r_tx_byte;
        w_tx_load_next   = 1'b0;
        w_reg_addr_next  = r_reg_addr;
        w_reg_we_next    = 1'b0;
        w_reg_wdata_next = r_reg_wdata;
        w_reg_re_next    = 1'b0;
        w_err_next       = r_err;

        if (!frame_active) begin
            // Frame end wins over everything except a write byte that
            // arrived in the very cycle the frame closed.
            w_state_next = IDLE;
            if (r_state == WR && rx_valid) begin
                w_reg_we_next    = 1'b1;
                w_reg_wdata_next = rx_byte;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_fa_prev) begin
                        w_state_next   = SYNC;
                        w_tx_load_next = 1'b1;
                        w_tx_byte_next = SYNC_BYTE;
                    end
                end
                SYNC: w_state_next = CMD;
                CMD: begin
                    if (rx_valid) begin
                        if (w_cmd_bad) begin
                            w_state_next = DONE;
                            w_err_next   = 1'b1;
                        end else begin
                            w_reg_addr_next = rx_byte[ADDR_W-1:0];
                            if (rx_byte[CMD_WR_BIT]) begin
                                w_state_next = WR;
                            end else begin
                                w_state_next  = RD_REQ;
                                w_reg_re_next = 1'b1;
                            end
                        end
                    end
                end
                WR: begin
`ifdef SPI_REG_CTRL_BURST_EN
                    // Advance once the strobe for the previous write is on the bus.
                    if (r_reg_we) begin
                        w_reg_addr_next = r_reg_addr + 1'b1;
                    end
`endif
                    if (rx_valid) begin
                        w_reg_we_next    = 1'b1;
                        w_reg_wdata_next = rx_byte;
`ifndef SPI_REG_CTRL_BURST_EN
                        w_state_next     = DONE;
`endif
                    end
                end
                RD_REQ: begin
                    w_state_next = RD_CAP;
                    if (rx_valid) w_err_next = 1'b1;
                end
                RD_CAP: begin
                    // reg_rdata is valid now, one cycle after reg_re.
                    w_state_next   = RD_LOAD;
                    w_tx_byte_next = reg_rdata;
                    w_tx_load_next = 1'b1;
                    if (rx_valid) w_err_next = 1'b1;
                end
                RD_LOAD: begin
                    w_state_next = RD_WAIT;
                    if (rx_valid) w_err_next = 1'b1;
                end
                RD_WAIT: begin
                    if (rx_valid) begin
`ifdef SPI_REG_CTRL_BURST_EN
                        w_state_next    = RD_REQ;
                        w_reg_addr_next = r_reg_addr + 1'b1;
                        w_reg_re_next   = 1'b1;
`else
                        w_state_next    = DONE;
`endif
                    end
                end
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end

        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        // Tracked through reset so a frame already open at reset release
        // is not mistaken for a new one.
        r_fa_prev <= frame_active;
        if (rst) begin
            r_state     <= IDLE;
            r_tx_byte   <= '0;
            r_tx_load   <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_we    <= 1'b0;
            r_reg_wdata <= '0;
            r_reg_re    <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tx_byte   <= w_tx_byte_next;
            r_tx_load   <= w_tx_load_next;
            r_reg_addr  <= w_reg_addr_next;
            r_reg_we    <= w_reg_we_next;
            r_reg_wdata <= w_reg_wdata_next;
            r_reg_re    <= w_reg_re_next;
            r_busy      <= w_busy_next;
            r_err       <= w_err_next;
        end
    end

    assign tx_byte   = r_tx_byte;
    assign tx_load   = r_tx_load;
    assign reg_addr  = r_reg_addr;
    assign reg_we    = r_reg_we;
    assign reg_wdata = r_reg_wdata;
    assign reg_re    = r_reg_re;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl
// Directed bench for spi_reg_ctrl (ADDR_W=4). Build with or without
// SPI_REG_CTRL_BURST_EN; expectations follow the same macro.
// Register bank model: register a reads back 8'hA2 + a (reg 5 = 8'hA7).
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [3:0] reg_addr;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int viol    = 0;
    logic prev_txl = 1'b0;

    logic [7:0] we_a[$], we_d[$], re_a[$], txl_b[$];
    int         we_c[$], re_c[$], txl_c[$];

    spi_reg_ctrl #(.ADDR_W(4), .SYNC_BYTE(8'h5A)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_active (frame_active),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_byte      (tx_byte),
        .tx_load      (tx_load),
        .reg_addr     (reg_addr),
        .reg_we       (reg_we),
        .reg_wdata    (reg_wdata),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank: read data valid exactly one cycle after reg_re.
    always @(posedge clk) reg_rdata <= reg_re ? (8'hA2 + {4'h0, reg_addr}) : 8'h00;

    // Bus/transmit monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reg_we) begin
            we_a.push_back({4'h0, reg_addr});
            we_d.push_back(reg_wdata);
            we_c.push_back(cyc);
        end
        if (reg_re) begin
            re_a.push_back({4'h0, reg_addr});
            re_c.push_back(cyc);
        end
        if (tx_load) begin
            txl_b.push_back(tx_byte);
            txl_c.push_back(cyc);
        end
        if (reg_we && reg_re) viol++;
        if (tx_load && prev_txl) viol++;
        prev_txl = tx_load;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_active = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_frame(output int t);
        @(posedge clk); #1;
        frame_active = 1'b1;
        t = cyc;
        repeat (3) @(posedge clk);
    endtask

    task automatic end_frame(output logic busy_after);
        @(posedge clk); #1;
        frame_active = 1'b0;
        @(posedge clk); #1;
        busy_after = busy;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output int t);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        t = cyc;
        $display("rx byte %02h at cycle %0d", b, t);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        int t_fa, t1, t2, nwe, nre, ntx;
        logic b_after;

        // ---------------- reset state
        do_reset();
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_tx_load", tx_load, 1'b0);
        chk("rst_addr", reg_addr, 4'h0);
        chk("rst_we", reg_we, 1'b0);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_re", reg_re, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);

        // ---------------- single write 0x83, 0x3C
        nwe = we_a.size(); ntx = txl_b.size();
        start_frame(t_fa);
        chk("wr_busy", busy, 1'b1);
        send_byte(8'h83, t1);
        send_byte(8'h3C, t2);
        end_frame(b_after);
        $display("frame write 83 3C done");
        chk("wr_sync_cnt", txl_b.size() - ntx, 1);
        chk("wr_sync_byte", txl_b[ntx], 8'h5A);
        chk("wr_sync_cyc", txl_c[ntx], t_fa + 1);
        chk("wr_we_cnt", we_a.size() - nwe, 1);
        chk("wr_addr", we_a[nwe], 8'h03);
        chk("wr_data", we_d[nwe], 8'h3C);
        chk("wr_cyc", we_c[nwe], t2 + 1);
        chk("wr_err", err, 1'b0);
        chk("wr_busy_end", b_after, 1'b0);

        // ---------------- single read of reg 5
        do_reset();
        nre = re_a.size(); ntx = txl_b.size();
        start_frame(t_fa);
        send_byte(8'h05, t1);
        chk("rd_re_cnt", re_a.size() - nre, 1);
        chk("rd_addr", re_a[nre], 8'h05);
        chk("rd_re_cyc", re_c[nre], t1 + 1);
        chk("rd_txl_cnt", txl_b.size() - ntx, 2);
        chk("rd_tx_byte", txl_b[ntx+1], 8'hA7);
        chk("rd_txl_cyc", txl_c[ntx+1], t1 + 3);
        send_byte(8'h00, t2);
`ifdef SPI_REG_CTRL_BURST_EN
        chk("rd_burst_re_cnt", re_a.size() - nre, 2);
        chk("rd_burst_addr", re_a[nre+1], 8'h06);
        chk("rd_burst_txl_cnt", txl_b.size() - ntx, 3);
        chk("rd_burst_byte", txl_b[ntx+2], 8'hA8);
`else
        chk("rd_single_re_cnt", re_a.size() - nre, 1);
        chk("rd_single_txl_cnt", txl_b.size() - ntx, 2);
`endif
        end_frame(b_after);
        $display("frame read 05 00 done");
        chk("rd_err", err, 1'b0);

        // ---------------- write 0x8E, 0x11, 0x22, 0x33 (wrap)
        do_reset();
        nwe = we_a.size();
        start_frame(t_fa);
        send_byte(8'h8E, t1);
        send_byte(8'h11, t1);
        send_byte(8'h22, t1);
        send_byte(8'h33, t1);
        end_frame(b_after);
        $display("frame write 8E 11 22 33 done");
`ifdef SPI_REG_CTRL_BURST_EN
        chk("burst_cnt", we_a.size() - nwe, 3);
        chk("burst_a0", we_a[nwe], 8'h0E);
        chk("burst_a1", we_a[nwe+1], 8'h0F);
        chk("burst_a2", we_a[nwe+2], 8'h00);
        chk("burst_d2", we_d[nwe+2], 8'h33);
`else
        chk("single_cnt", we_a.size() - nwe, 1);
        chk("single_a0", we_a[nwe], 8'h0E);
        chk("single_d0", we_d[nwe], 8'h11);
`endif

        // ---------------- invalid command 0x70
        do_reset();
        nwe = we_a.size(); nre = re_a.size(); ntx = txl_b.size();
        start_frame(t_fa);
        send_byte(8'h70, t1);
        chk("inv_err", err, 1'b1);
        send_byte(8'h85, t1);
        send_byte(8'h44, t1);
        chk("inv_busy", busy, 1'b1);
        end_frame(b_after);
        $display("frame invalid 70 done");
        chk("inv_strobes", (we_a.size() - nwe) + (re_a.size() - nre), 0);
        chk("inv_txl_cnt", txl_b.size() - ntx, 1);
        chk("inv_err_sticky", err, 1'b1);

        // ---------------- overrun: byte right after a read command
        do_reset();
        ntx = txl_b.size();
        start_frame(t_fa);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_byte = 8'h05; t1 = cyc;
        @(posedge clk); #1;
        rx_byte = 8'hFF;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (5) @(posedge clk);
        end_frame(b_after);
        $display("frame overrun read 05 done");
        chk("ovr_err", err, 1'b1);
        chk("ovr_txl_cnt", txl_b.size() - ntx, 2);
        chk("ovr_tx_byte", txl_b[ntx+1], 8'hA7);
        chk("ovr_txl_cyc", txl_c[ntx+1], t1 + 3);

        // ---------------- reset during RD_CAP
        do_reset();
        ntx = txl_b.size();
        start_frame(t_fa);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_byte = 8'h05; t1 = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;              // cycle t1+1: RD_REQ
        @(posedge clk); #1;
        rst = 1'b1;                   // cycle t1+2: RD_CAP
        @(posedge clk); #1;
        chk("mid_rst_outs", {tx_byte, tx_load, reg_we, reg_re, busy, err, reg_wdata, reg_addr}, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_txl", txl_b.size() - ntx, 1);
        end_frame(b_after);
        $display("frame reset mid-read done");

        // ---------------- frame abort before data byte
        do_reset();
        nwe = we_a.size();
        start_frame(t_fa);
        send_byte(8'h83, t1);
        end_frame(b_after);
        $display("frame abort before data done");
        chk("abort_busy", b_after, 1'b0);
        chk("abort_we_cnt", we_a.size() - nwe, 0);

        // ---------------- data byte coincident with frame drop
        nwe = we_a.size();
        start_frame(t_fa);
        send_byte(8'h83, t1);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_byte = 8'h5E; frame_active = 1'b0; t2 = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("coinc_busy", busy, 1'b0);
        repeat (4) @(posedge clk);
        $display("frame abort coincident with data done");
        chk("coinc_we_cnt", we_a.size() - nwe, 1);
        chk("coinc_addr", we_a[nwe], 8'h03);
        chk("coinc_data", we_d[nwe], 8'h5E);
        chk("coinc_cyc", we_c[nwe], t2 + 1);

        chk("invariants", viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
